// File: rtl/mac_pkg.sv
// Shared types and constants for the streamed 3x3 matrix engine.
package mac_pkg;

    typedef enum logic [1:0] {
        OP_MADD = 2'b00,
        OP_MSUB = 2'b01,
        OP_MMUL = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_COMPUTE,
        S_DRAIN
    } state_e;

    localparam int DEF_VAR_WIDTH = 8;
    localparam int DEF_MAT_SIZE  = 3;
    localparam int NUM_ELEM      = DEF_MAT_SIZE * DEF_MAT_SIZE;

endpackage

// File: rtl/mat_alu_step.sv
// Single-element arithmetic step: add, subtract or one multiply-accumulate term.
module mat_alu_step
    import mac_pkg::*;
#(
    parameter int VAR_WIDTH = DEF_VAR_WIDTH
) (
    input  logic [VAR_WIDTH-1:0] a,
    input  logic [VAR_WIDTH-1:0] b,
    input  logic [VAR_WIDTH-1:0] acc,
    input  op_e                  op,
    input  logic                 first_k,
    output logic [VAR_WIDTH-1:0] nxt
);

    logic [VAR_WIDTH-1:0] prod;
    logic [VAR_WIDTH-1:0] base;

    // Only the low VAR_WIDTH bits of the product matter under modulo arithmetic.
    assign prod = a * b;
    assign base = first_k ? '0 : acc;

    always_comb begin
        nxt = '0;
        case (op)
            OP_MADD: nxt = a + b;
            OP_MSUB: nxt = a - b;
            OP_MMUL: nxt = base + prod;
            default: nxt = '0;
        endcase
    end

endmodule

// File: rtl/mat_stream_engine.sv
// Element-streamed matrix engine: loads A then B, computes on one shared ALU, drains R.
module mat_stream_engine
    import mac_pkg::*;
#(
    parameter int VAR_WIDTH = DEF_VAR_WIDTH,
    parameter int MAT_SIZE  = DEF_MAT_SIZE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [1:0]           opcode_i,
    output logic                 busy_o,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [VAR_WIDTH-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [VAR_WIDTH-1:0] out_data_o,
    output logic                 out_last_o,
    output logic                 done_o
);

    localparam int NE = MAT_SIZE * MAT_SIZE;
    localparam int IW = $clog2(NE);
    localparam int CW = $clog2(MAT_SIZE);
    localparam logic [IW-1:0] LAST_E = IW'(NE - 1);
    localparam logic [CW-1:0] LAST_C = CW'(MAT_SIZE - 1);
    localparam logic [IW-1:0] MS     = IW'(MAT_SIZE);

    state_e               state;
    op_e                  op;
    logic [IW-1:0]        cnt;
    logic [IW-1:0]        didx;
    logic [CW-1:0]        row, col, kk;
    logic [VAR_WIDTH-1:0] acc;
    logic [VAR_WIDTH-1:0] alu_nxt;

    logic [VAR_WIDTH-1:0] a_mem [NE];
    logic [VAR_WIDTH-1:0] b_mem [NE];
    logic [VAR_WIDTH-1:0] r_mem [NE];

    logic          is_mul, first_k, last_k, in_hs;
    logic [IW-1:0] a_idx, b_idx, r_idx;

    assign is_mul  = (op == OP_MMUL);
    assign first_k = (kk == '0);
    assign last_k  = !is_mul || (kk == LAST_C);
    assign in_hs   = in_valid_i && in_ready_o;

    // Element-wise ops walk R in row-major order; MMUL adds an inner k loop.
    assign r_idx = IW'(row) * MS + IW'(col);
    assign a_idx = is_mul ? IW'(row) * MS + IW'(kk) : r_idx;
    assign b_idx = is_mul ? IW'(kk) * MS + IW'(col) : r_idx;

    mat_alu_step #(.VAR_WIDTH(VAR_WIDTH)) u_alu (
        .a       (a_mem[a_idx]),
        .b       (b_mem[b_idx]),
        .acc     (acc),
        .op      (op),
        .first_k (first_k),
        .nxt     (alu_nxt)
    );

    assign out_data_o = out_valid_o ? r_mem[didx] : '0;
    assign out_last_o = out_valid_o && (didx == LAST_E);

    // Operand/result storage carries no reset; contents are only read after being written.
    always_ff @(posedge clk_i) begin
        if (state == S_LOAD_A && in_hs) a_mem[cnt] <= in_data_i;
        if (state == S_LOAD_B && in_hs) b_mem[cnt] <= in_data_i;
        if (state == S_COMPUTE && last_k) r_mem[r_idx] <= alu_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            op          <= OP_MADD;
            cnt         <= '0;
            didx        <= '0;
            row         <= '0;
            col         <= '0;
            kk          <= '0;
            acc         <= '0;
            busy_o      <= 1'b0;
            in_ready_o  <= 1'b0;
            out_valid_o <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        op         <= op_e'(opcode_i);
                        cnt        <= '0;
                        state      <= S_LOAD_A;
                        busy_o     <= 1'b1;
                        in_ready_o <= 1'b1;
                    end
                end
                S_LOAD_A: begin
                    if (in_hs) begin
                        if (cnt == LAST_E) begin
                            cnt   <= '0;
                            state <= S_LOAD_B;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_LOAD_B: begin
                    if (in_hs) begin
                        if (cnt == LAST_E) begin
                            cnt        <= '0;
                            state      <= S_COMPUTE;
                            in_ready_o <= 1'b0;
                            row        <= '0;
                            col        <= '0;
                            kk         <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    acc <= alu_nxt;
                    if (last_k) begin
                        kk <= '0;
                        if (col == LAST_C) begin
                            col <= '0;
                            if (row == LAST_C) begin
                                row         <= '0;
                                didx        <= '0;
                                state       <= S_DRAIN;
                                out_valid_o <= 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end else begin
                        kk <= kk + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (out_ready_i) begin
                        if (didx == LAST_E) begin
                            state       <= S_IDLE;
                            out_valid_o <= 1'b0;
                            busy_o      <= 1'b0;
                            done_o      <= 1'b1;
                        end else begin
                            didx <= didx + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mat_stream_engine.sv
// Directed scoreboard bench for mat_stream_engine.
module tb_mat_stream_engine;
    import mac_pkg::*;

    typedef logic [7:0] mat_t [NUM_ELEM];

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic [1:0] opcode_i = 2'b00;
    logic       busy_o;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic [7:0] in_data_i = 8'h00;
    logic       out_valid_o;
    logic       out_ready_i = 1'b1;
    logic [7:0] out_data_o;
    logic       out_last_o;
    logic       done_o;

    logic [7:0] exp_q [$];
    int total = 0;
    int bad = 0;

    mat_stream_engine #(.VAR_WIDTH(8), .MAT_SIZE(3)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .opcode_i    (opcode_i),
        .busy_o      (busy_o),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic abort(input string tag);
        total++;
        bad++;
        $display("FAIL %s timeout", tag);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    function automatic mat_t model(input logic [1:0] op, input mat_t a, input mat_t b);
        mat_t r;
        logic [7:0] s;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                case (op)
                    2'b00: r[i*3+j] = a[i*3+j] + b[i*3+j];
                    2'b01: r[i*3+j] = a[i*3+j] - b[i*3+j];
                    2'b10: begin
                        s = 8'h00;
                        for (int k = 0; k < 3; k++) s = s + a[i*3+k] * b[k*3+j];
                        r[i*3+j] = s;
                    end
                    default: r[i*3+j] = 8'h00;
                endcase
            end
        return r;
    endfunction

    // Starts a job and streams A then B; optional random in_valid gaps and a stray start in LOAD_B.
    task automatic load(input logic [1:0] op, input mat_t a, input mat_t b, input bit gaps, input bit stray);
        mat_t r;
        bit rdy, taken;
        int tries;
        r = model(op, a, b);
        for (int i = 0; i < NUM_ELEM; i++) exp_q.push_back(r[i]);
        start_i = 1'b1;
        opcode_i = op;
        @(negedge clk);
        start_i = 1'b0;
        opcode_i = ~op;
        for (int e = 0; e < 2 * NUM_ELEM; e++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid_i = 1'b0;
                in_data_i = 8'($urandom);
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            in_valid_i = 1'b1;
            in_data_i = (e < NUM_ELEM) ? a[e] : b[e-NUM_ELEM];
            taken = 1'b0;
            tries = 0;
            while (!taken) begin
                rdy = in_ready_o;
                start_i = stray && (e == 12);
                opcode_i = 2'b00;
                @(negedge clk);
                taken = rdy;
                tries++;
                if (tries > 20) abort("load_ready");
            end
            start_i = 1'b0;
        end
        in_valid_i = 1'b0;
    endtask

    task automatic wait_valid(input int lat);
        int n = 0;
        while (!out_valid_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("first_valid_latency", n, lat);
    endtask

    // Pops the scoreboard per result; optional stall and stray start during DRAIN.
    task automatic drain(input int stall_at, input int stall_len, input int start_at);
        logic [7:0] d0, e;
        bit stable;
        for (int idx = 0; idx < NUM_ELEM; idx++) begin
            if (idx == stall_at) begin
                out_ready_i = 1'b0;
                d0 = out_data_o;
                stable = 1'b1;
                repeat (stall_len) begin
                    @(negedge clk);
                    if (!out_valid_o || out_data_o !== d0 || out_last_o) stable = 1'b0;
                end
                chk("stall_hold", {31'd0, stable}, 32'd1);
                out_ready_i = 1'b1;
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            chk("out_valid", {31'd0, out_valid_o}, 32'd1);
            chk($sformatf("out_data[%0d]", idx), {24'd0, out_data_o}, {24'd0, e});
            chk("out_last", {31'd0, out_last_o}, {31'd0, idx == NUM_ELEM - 1});
            chk("done_early", {31'd0, done_o}, 32'd0);
            if (idx == start_at) begin
                start_i = 1'b1;
                opcode_i = 2'b00;
            end
            @(negedge clk);
            start_i = 1'b0;
        end
        chk("done_pulse", {31'd0, done_o}, 32'd1);
        chk("busy_after", {31'd0, busy_o}, 32'd0);
        chk("valid_after", {31'd0, out_valid_o}, 32'd0);
        chk("data_zero_idle", {24'd0, out_data_o}, 32'd0);
        @(negedge clk);
        chk("done_single", {31'd0, done_o}, 32'd0);
        chk("busy_idle", {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        mat_t a, b;

        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_out_data", {24'd0, out_data_o}, 32'd0);
        chk("rst_out_last", {31'd0, out_last_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk);

        // MADD 1..9 + 1
        for (int i = 0; i < NUM_ELEM; i++) begin a[i] = 8'(i + 1); b[i] = 8'd1; end
        load(2'b00, a, b, 0, 0);
        chk("busy_compute", {31'd0, busy_o}, 32'd1);
        wait_valid(9);
        drain(-1, 0, -1);

        // MSUB 0 - 1
        for (int i = 0; i < NUM_ELEM; i++) begin a[i] = 8'd0; b[i] = 8'd1; end
        load(2'b01, a, b, 0, 0);
        wait_valid(9);
        drain(-1, 0, -1);

        // MMUL identity x 1..9
        for (int i = 0; i < NUM_ELEM; i++) begin a[i] = (i % 4 == 0) ? 8'd1 : 8'd0; b[i] = 8'(i + 1); end
        load(2'b10, a, b, 0, 0);
        wait_valid(27);
        drain(-1, 0, -1);

        // MMUL all 2 x all 3
        for (int i = 0; i < NUM_ELEM; i++) begin a[i] = 8'd2; b[i] = 8'd3; end
        load(2'b10, a, b, 0, 0);
        wait_valid(27);
        drain(-1, 0, -1);

        // MMUL overflow wrap
        for (int i = 0; i < NUM_ELEM; i++) begin a[i] = 8'h10; b[i] = 8'h10; end
        load(2'b10, a, b, 0, 0);
        wait_valid(27);
        drain(-1, 0, -1);

        // Random MMUL with in_valid gaps and output stall at element 4
        for (int i = 0; i < NUM_ELEM; i++) begin a[i] = 8'($urandom); b[i] = 8'($urandom); end
        load(2'b10, a, b, 1, 0);
        wait_valid(27);
        drain(4, 5, -1);

        // Reserved opcode with stray starts in LOAD_B and DRAIN
        for (int i = 0; i < NUM_ELEM; i++) begin a[i] = 8'($urandom | 1); b[i] = 8'($urandom | 1); end
        load(2'b11, a, b, 0, 1);
        wait_valid(9);
        drain(-1, 0, 2);

        // Reset in the middle of an MMUL compute
        load(2'b10, a, b, 0, 0);
        repeat (5) @(negedge clk);
        chk("busy_pre_reset", {31'd0, busy_o}, 32'd1);
        rst_i = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("mid_rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready_o}, 32'd0);
        rst_i = 1'b0;
        exp_q.delete();
        @(negedge clk);

        // Fresh MADD after reset
        for (int i = 0; i < NUM_ELEM; i++) begin a[i] = 8'(8'hF0 + i); b[i] = 8'(3 * i); end
        load(2'b00, a, b, 0, 0);
        wait_valid(9);
        drain(-1, 0, -1);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
